// File: rtl/fetch_queue.sv
// Instruction prefetch queue for the 6502 core: streams program bytes into a small
// byte FIFO and hands one complete instruction per handshake to the decoder.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect,
  input  logic [15:0] i_target,
  input  logic        i_bus_free,
  output logic        o_rd,
  output logic [15:0] o_addr,
  input  logic [7:0]  i_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [7:0]  o_opcode,
  output logic [15:0] o_operand,
  output logic [1:0]  o_len,
  output logic [15:0] o_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = 8 * DEPTH;

  logic [FW-1:0] fifo;
  logic [FW-1:0] fifo_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_kept;
  logic [CW-1:0] count_next;
  logic          inflight;
  logic          started;
  logic [15:0]   fetch_ptr;
  logic [15:0]   head_pc;
  logic [7:0]    head_op;
  logic [1:0]    head_len;
  logic          pop;

  // Opcode aaa_bbb_cc: special cases first, then the column-based rules.
  function automatic logic [1:0] insn_len(input logic [7:0] op);
    if (op == 8'h20)
      return 2'd3;
    else if (op == 8'h40 || op == 8'h60)
      return 2'd1;
    else if (op == 8'h00)
      return 2'd2;
    else if (op[3:2] == 2'b10 && !op[0])
      return 2'd1;
    else if (op[4:2] == 3'b011 || op[4:2] == 3'b111 || (op[4:2] == 3'b110 && op[0]))
      return 2'd3;
    else
      return 2'd2;
  endfunction

  assign head_op  = fifo[7:0];
  assign head_len = insn_len(head_op);
  assign o_valid  = count >= CW'(head_len);
  assign pop      = o_valid & i_ready;
  assign o_addr   = fetch_ptr;
  assign o_pc     = head_pc;

  // Capacity counts the byte still on its way back so a push always has room.
  assign o_rd = started & i_bus_free & ~i_redirect &
                (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(DEPTH));

  always_comb begin
    fifo_next  = fifo >> {(pop ? head_len : 2'd0), 3'b000};
    count_kept = count - (pop ? CW'(head_len) : '0);
    for (int i = 0; i < DEPTH; i++) begin
      if (inflight && i == int'(count_kept))
        fifo_next[8*i +: 8] = i_data;
    end
    count_next = count_kept + CW'(inflight);
  end

  always_comb begin
    o_opcode  = '0;
    o_operand = '0;
    o_len     = '0;
    if (o_valid) begin
      o_opcode = head_op;
      o_len    = head_len;
      if (head_len == 2'd3)
        o_operand = fifo[23:8];
      else if (head_len == 2'd2)
        o_operand = {8'h00, fifo[15:8]};
    end
  end

  // A redirect overrides every queue update, which also drops any returning byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo      <= '0;
      count     <= '0;
      inflight  <= 1'b0;
      started   <= 1'b0;
      fetch_ptr <= '0;
      head_pc   <= '0;
    end else if (i_redirect) begin
      count     <= '0;
      inflight  <= 1'b0;
      started   <= 1'b1;
      fetch_ptr <= i_target;
      head_pc   <= i_target;
    end else begin
      fifo     <= fifo_next;
      count    <= count_next;
      inflight <= o_rd;
      if (o_rd)
        fetch_ptr <= fetch_ptr + 16'd1;
      if (pop)
        head_pc <= head_pc + 16'(head_len);
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch/prefetch front end of the 6502 core. It produces the opcode stream that the opcode decoder consumes.
- Reads program bytes sequentially over a fixed-latency read port into a small byte FIFO.
- Determines instruction length from the opcode.
- Presents one complete instruction (opcode, operands, length, PC) per valid/ready handshake to the decode/control stage.
- Flushes and restarts on a redirect (jump, branch, interrupt vector, reset vector).

Parameters:
- DEPTH, 4, byte FIFO entries; legal range 3..8.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active low.
- i_redirect  in  1  flush the queue and restart fetch at i_target.
- i_target  in  16  redirect address.
- i_bus_free  in  1  core is not using the bus this cycle; fetch read allowed.
- o_rd  out  1  read strobe.
- o_addr  out  16  read address.
- i_data  in  8  read data, valid the cycle after an accepted o_rd.
- o_valid  out  1  complete instruction available.
- i_ready  in  1  consumer accepts the instruction.
- o_opcode  out  8  opcode byte.
- o_operand  out  16  {byte2, byte1}; absent bytes are 0.
- o_len  out  2  instruction length, 1..3.
- o_pc  out  16  address of the opcode byte.

Behaviour:
- Reset (async, i_rst_n=0):
  - FIFO empty, in-flight flag 0, fetch pointer 0, head PC 0.
  - All outputs 0.
  - The block stays idle (no o_rd) until the first i_redirect.
- Length rule (opcode aaa_bbb_cc), evaluated in priority order:
  - 0x20 (JSR) -> 3.
  - 0x40 and 0x60 (RTI, RTS) -> 1.
  - 0x00 (BRK) -> 2.
  - ???_?10_?0 -> 1.
  - bbb=011, bbb=111, or (bbb=110 and c0=1) -> 3.
  - All others -> 2.
  - Undocumented opcodes follow the same columns.
- Read issue:
  - o_rd = started & i_bus_free & (count + inflight < DEPTH) & !i_redirect.
  - o_addr = fetch pointer. On an accepted read (o_rd at the edge) the fetch pointer increments modulo 2^16 (FFFF -> 0000) and inflight is set.
  - On the following edge, i_data is pushed to the FIFO tail and inflight clears unless a new read was accepted in the same edge.
  - Sustained throughput is one byte per cycle.
- Output:
  - o_valid = (count >= len(head byte)), combinational from registered FIFO state only. There is no bypass from i_data.
  - o_opcode/o_operand/o_len/o_pc are driven from FIFO entries 0..2 and the head-PC register.
  - While o_valid & !i_ready, all outputs hold stable.
  - When o_valid is 0, o_opcode/o_operand/o_len are 0; o_pc still shows the head PC.
- Transfer (o_valid & i_ready at the edge):
  - Pop len bytes; head PC += len modulo 2^16.
  - A push and a pop in the same edge give count' = count + 1 - len.
- Redirect (i_redirect at the edge):
  - count = 0, head PC = fetch pointer = i_target.
  - Any byte returning next cycle from an in-flight read is discarded; it is not pushed.
  - A transfer completing in the same edge still counts as accepted; redirect wins over all FIFO updates.
  - Fetch resumes the cycle after the edge. For a 1-byte instruction at the target with the bus free, the first o_valid comes 2 cycles after the redirect edge.
- Redirect while in reset is ignored.
- Async reset mid-read: the returning byte is dropped and outputs go to 0 immediately.

Test Plan:
- Redirect to 0x0200; memory holds A9 05 8D 00 02 EA; i_ready=1 -> three transfers in order:
  - {A9, 0005, 2, 0200}
  - {8D, 0200, 3, 0202}
  - {EA, 0000, 1, 0205}
- Same program with i_ready=0 for 8 cycles -> outputs stable at {A9, 0005, 2, 0200}; o_rd stops once count = DEPTH = 4; no bytes lost after release.
- Redirect to 0x0300 the cycle after a read of 0x0203 was accepted -> the 0x0203 byte is dropped; next transfer has o_pc=0300 with 0x0300 contents.
- Wrap: redirect to 0xFFFE; memory holds 4C 34 12 at FFFE/FFFF/0000 -> transfer {4C, 1234, 3, FFFE}; next o_pc=0001; o_addr sequence FFFE, FFFF, 0000, 0001.
- Length table via a redirect per opcode:
  - 00 -> 2
  - 40 -> 1
  - 60 -> 1
  - 20 -> 3
  - 18 -> 1
  - 0A -> 1
  - B9 -> 3
  - BD -> 3
  - B1 -> 2
  - A2 -> 2
  - 6C -> 3
- i_bus_free toggled 1,0,1,0 -> o_rd only in free cycles, addresses contiguous. Assert i_rst_n=0 mid-stream -> o_valid, o_rd, and outputs 0 immediately; no o_rd after release until a redirect.
